memory_access: RTL and testbench
================================

Name: memory_access

Overview:
- Pipeline stage directly downstream of the execute stage. It consumes the execute stage's result, destination select, PC, memory read/write enables, store data and access size.
- Issues load/store transactions to the data memory over a req/ack handshake, aligns and sign/zero-extends load data, and forwards results to writeback.
- Stalls upstream while a transaction is outstanding.

Parameters:
- WIDTH, 32: datapath width; only 32 is supported (4 byte lanes).
- TIMEOUT, 255: max WAIT cycles before a bus fault; 0 disables the timeout.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- halt  input  1  freeze request from downstream/debug
- i_rd  input  WIDTH  execute result; the byte address when a memory op is present
- i_rd_sel  input  WIDTH  destination register select (0 = none)
- i_pc  input  WIDTH  instruction PC
- sig_i_mem_wr_en  input  1  store request
- sig_i_mem_rd_en  input  1  load request
- i_mem_wr_data  input  WIDTH  store data
- i_mem_rw_size  input  3  funct3 size code: 0 B, 1 H, 2 W, 4 BU, 5 HU
- o_stall  output  1  combinational; upstream holds its outputs
- o_rd  output  WIDTH  writeback value
- o_rd_sel  output  WIDTH  writeback select
- o_pc  output  WIDTH  PC forwarded to writeback
- o_fault  output  1  one-cycle pulse on misaligned, illegal or timed-out access
- dmem_req  output  1  bus request (registered)
- dmem_we  output  1  1 = write
- dmem_addr  output  WIDTH  word-aligned address, {addr[31:2],2'b00}
- dmem_wdata  output  WIDTH  lane-replicated store data
- dmem_wstrb  output  4  byte strobes; 0 on reads
- dmem_ack  input  1  transaction complete; read data valid this cycle
- dmem_rdata  input  WIDTH  read word

Behaviour:
- Reset: state IDLE. All outputs 0; the latched address, data, size, select, PC and timeout counter are cleared. Reset mid-transaction abandons it and drops dmem_req on the next edge.
- mem_op = sig_i_mem_wr_en | sig_i_mem_rd_en.
- o_stall = (state==WAIT) | (state==IDLE & mem_op & !halt).
- State IDLE:
  - halt=1: o_rd, o_rd_sel and o_fault are written 0 (bubble); o_pc holds; nothing is accepted.
  - No mem_op: o_rd<=i_rd, o_rd_sel<=i_rd_sel, o_pc<=i_pc. Latency 1 cycle.
  - mem_op with a fault condition: writeback a bubble (o_rd_sel<=0, o_rd<=0), o_pc<=i_pc, o_fault<=1 for one cycle, stay IDLE, no bus activity.
  - Fault conditions:
    - both enables set
    - size code 3, 6 or 7
    - store size code 4 or 5
    - H/HU with addr[0]=1
    - W with addr[1:0]!=0
  - Otherwise: latch the op. Set dmem_req<=1, dmem_we<=wr_en, dmem_addr, dmem_wdata, dmem_wstrb. Clear the timeout counter. Writeback a bubble. Go to WAIT.
- Store lanes:
  - B: wdata={4{d[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - H: wdata={2{d[15:0]}}, wstrb=4'b0011<<(2*addr[1]).
  - W: wdata=d, wstrb=4'b1111.
- State WAIT:
  - Bus signals are held stable until dmem_ack, regardless of halt.
  - On dmem_ack: dmem_req<=0, dmem_wstrb<=0. For a load, latch the extracted value; for a store, latch value 0 with select 0. Go to DONE.
  - Load extraction: byte=rdata>>(8*addr[1:0]), half=rdata>>(16*addr[1]). Sign-extend for codes 0 and 1; zero-extend for 4 and 5.
  - The counter increments each WAIT cycle without ack. When it reaches TIMEOUT (TIMEOUT>0): drop dmem_req, o_fault pulse, bubble, go to DONE. An ack arriving in the same cycle as the timeout wins.
- State DONE:
  - o_stall=0, so upstream advances the held instruction at this edge. Input is ignored (no re-issue).
  - halt=0: o_rd<=latched value, o_rd_sel<=latched select, o_pc<=latched PC; go to IDLE.
  - halt=1: stay in DONE with outputs held.
- Load-to-writeback latency is 3 edges plus the ack wait. dmem_ack outside WAIT is ignored.

Test Plan:
- ALU op i_rd=0x1234, i_rd_sel=5, no enables -> next cycle o_rd=0x1234, o_rd_sel=5; o_stall never high; dmem_req stays 0.
- SB: addr 0x103, data 0xAB, size 0 -> dmem_addr=0x100, wdata=0xABABABAB, wstrb=4'b1000, we=1. With ack after 2 cycles: o_stall high 3 cycles, then o_rd_sel=0.
- LH: addr 0x102, rdata=0x8001_0000, ack immediate -> o_rd=0xFFFF8001. Same access with LHU -> o_rd=0x00008001. o_rd_sel equals the issued select.
- LW: addr 0x101 -> o_fault pulses 1 cycle, dmem_req never rises, o_rd_sel=0. Same bubble for size code 3 and for both enables set.
- TIMEOUT=4, LW with no ack -> dmem_req drops after 4 WAIT cycles, o_fault pulses, stall released. Ack in the 4th cycle -> normal load completes, no fault.
- Reset asserted in WAIT -> next edge: dmem_req=0, state IDLE, all outputs 0. A halt held during DONE keeps the outputs until it is released.

Source files
------------

// File: rtl/memory_access_if.sv
// rtl/memory_access_if.sv - data memory req/ack bus between the memory stage and the data memory
`timescale 1ns/1ps

interface memory_access_if #(
    parameter int WIDTH = 32
);
    logic             dmem_req;
    logic             dmem_we;
    logic [WIDTH-1:0] dmem_addr;
    logic [WIDTH-1:0] dmem_wdata;
    logic [3:0]       dmem_wstrb;
    logic             dmem_ack;
    logic [WIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_wstrb,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_wstrb,
        output dmem_ack,
        output dmem_rdata
    );
endinterface

// File: rtl/memory_access.sv
// rtl/memory_access.sv - memory pipeline stage: issues loads/stores, aligns load data, forwards to writeback
`timescale 1ns/1ps

module memory_access #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             halt,
    input  logic [WIDTH-1:0] i_rd,
    input  logic [WIDTH-1:0] i_rd_sel,
    input  logic [WIDTH-1:0] i_pc,
    input  logic             sig_i_mem_wr_en,
    input  logic             sig_i_mem_rd_en,
    input  logic [WIDTH-1:0] i_mem_wr_data,
    input  logic [2:0]       i_mem_rw_size,
    output logic             o_stall,
    output logic [WIDTH-1:0] o_rd,
    output logic [WIDTH-1:0] o_rd_sel,
    output logic [WIDTH-1:0] o_pc,
    output logic             o_fault,
    memory_access_if.master  dmem
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t           state;
    logic [1:0]       lat_lane;
    logic [2:0]       lat_size;
    logic             lat_we;
    logic [WIDTH-1:0] lat_sel;
    logic [WIDTH-1:0] lat_pc;
    logic [WIDTH-1:0] lat_val;
    logic [CW-1:0]    wait_cnt;

    logic             mem_op;
    logic             access_fault;
    logic [1:0]       lane;
    logic [WIDTH-1:0] st_wdata;
    logic [3:0]       st_wstrb;
    logic [WIDTH-1:0] rd_byte_sh;
    logic [WIDTH-1:0] rd_half_sh;
    logic [WIDTH-1:0] ld_value;

    assign mem_op  = sig_i_mem_wr_en | sig_i_mem_rd_en;
    assign lane    = i_rd[1:0];
    assign o_stall = (state == WAIT) | ((state == IDLE) & mem_op & ~halt);

    always_comb begin
        access_fault = 1'b0;
        case (i_mem_rw_size)
            3'd0, 3'd4: begin
            end
            3'd1, 3'd5: if (i_rd[0]) access_fault = 1'b1;
            3'd2:       if (lane != 2'b00) access_fault = 1'b1;
            default:    access_fault = 1'b1;
        endcase
        // Unsigned sizes only make sense for loads.
        if (sig_i_mem_wr_en && i_mem_rw_size[2]) access_fault = 1'b1;
        if (sig_i_mem_wr_en && sig_i_mem_rd_en)  access_fault = 1'b1;
    end

    always_comb begin
        st_wdata = i_mem_wr_data;
        st_wstrb = 4'b1111;
        case (i_mem_rw_size[1:0])
            2'd0: begin
                st_wdata = {4{i_mem_wr_data[7:0]}};
                st_wstrb = 4'b0001 << lane;
            end
            2'd1: begin
                st_wdata = {2{i_mem_wr_data[15:0]}};
                st_wstrb = 4'b0011 << {lane[1], 1'b0};
            end
            default: begin
                st_wdata = i_mem_wr_data;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    assign rd_byte_sh = dmem.dmem_rdata >> {lat_lane, 3'b000};
    assign rd_half_sh = dmem.dmem_rdata >> {lat_lane[1], 4'b0000};

    always_comb begin
        ld_value = dmem.dmem_rdata;
        case (lat_size)
            3'd0:    ld_value = {{(WIDTH-8){rd_byte_sh[7]}}, rd_byte_sh[7:0]};
            3'd1:    ld_value = {{(WIDTH-16){rd_half_sh[15]}}, rd_half_sh[15:0]};
            3'd4:    ld_value = {{(WIDTH-8){1'b0}}, rd_byte_sh[7:0]};
            3'd5:    ld_value = {{(WIDTH-16){1'b0}}, rd_half_sh[15:0]};
            default: ld_value = dmem.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            lat_lane        <= '0;
            lat_size        <= '0;
            lat_we          <= 1'b0;
            lat_sel         <= '0;
            lat_pc          <= '0;
            lat_val         <= '0;
            wait_cnt        <= '0;
            o_rd            <= '0;
            o_rd_sel        <= '0;
            o_pc            <= '0;
            o_fault         <= 1'b0;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
            dmem.dmem_wstrb <= 4'b0000;
        end else begin
            o_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (halt) begin
                        o_rd     <= '0;
                        o_rd_sel <= '0;
                    end else if (!mem_op) begin
                        o_rd     <= i_rd;
                        o_rd_sel <= i_rd_sel;
                        o_pc     <= i_pc;
                    end else if (access_fault) begin
                        o_rd     <= '0;
                        o_rd_sel <= '0;
                        o_pc     <= i_pc;
                        o_fault  <= 1'b1;
                    end else begin
                        lat_lane        <= lane;
                        lat_size        <= i_mem_rw_size;
                        lat_we          <= sig_i_mem_wr_en;
                        lat_sel         <= i_rd_sel;
                        lat_pc          <= i_pc;
                        wait_cnt        <= '0;
                        dmem.dmem_req   <= 1'b1;
                        dmem.dmem_we    <= sig_i_mem_wr_en;
                        dmem.dmem_addr  <= {i_rd[WIDTH-1:2], 2'b00};
                        dmem.dmem_wdata <= st_wdata;
                        dmem.dmem_wstrb <= sig_i_mem_wr_en ? st_wstrb : 4'b0000;
                        o_rd            <= '0;
                        o_rd_sel        <= '0;
                        state           <= WAIT;
                    end
                end
                WAIT: begin
                    // An ack coinciding with the final timeout cycle still completes normally.
                    if (dmem.dmem_ack) begin
                        dmem.dmem_req   <= 1'b0;
                        dmem.dmem_wstrb <= 4'b0000;
                        lat_val         <= lat_we ? '0 : ld_value;
                        if (lat_we) lat_sel <= '0;
                        state           <= DONE;
                    end else if (TIMEOUT > 0 && wait_cnt == CNT_LAST) begin
                        dmem.dmem_req   <= 1'b0;
                        dmem.dmem_wstrb <= 4'b0000;
                        lat_val         <= '0;
                        lat_sel         <= '0;
                        o_fault         <= 1'b1;
                        state           <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (!halt) begin
                        o_rd     <= lat_val;
                        o_rd_sel <= lat_sel;
                        o_pc     <= lat_pc;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - directed bench for memory_access with a transaction-level expectation model
`timescale 1ns/1ps

module tb_memory_access;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        halt;
    logic [31:0] i_rd, i_rd_sel, i_pc, i_mem_wr_data;
    logic        wr_en, rd_en;
    logic [2:0]  rw_size;
    logic        o_stall, o_fault;
    logic [31:0] o_rd, o_rd_sel, o_pc;

    memory_access_if #(.WIDTH(32)) bus ();

    memory_access #(.WIDTH(32), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .reset           (reset),
        .halt            (halt),
        .i_rd            (i_rd),
        .i_rd_sel        (i_rd_sel),
        .i_pc            (i_pc),
        .sig_i_mem_wr_en (wr_en),
        .sig_i_mem_rd_en (rd_en),
        .i_mem_wr_data   (i_mem_wr_data),
        .i_mem_rw_size   (rw_size),
        .o_stall         (o_stall),
        .o_rd            (o_rd),
        .o_rd_sel        (o_rd_sel),
        .o_pc            (o_pc),
        .o_fault         (o_fault),
        .dmem            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic        m_stall, m_req, m_we, m_fault;
    logic [31:0] m_rd, m_sel, m_pc, m_addr, m_wdata;
    logic [3:0]  m_wstrb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("o_stall", 32'(o_stall), 32'(m_stall));
            check("dmem_req", 32'(bus.dmem_req), 32'(m_req));
            check("dmem_wstrb", 32'(bus.dmem_wstrb), 32'(m_wstrb));
            check("o_fault", 32'(o_fault), 32'(m_fault));
            check("o_rd", o_rd, m_rd);
            check("o_rd_sel", o_rd_sel, m_sel);
            check("o_pc", o_pc, m_pc);
            if (m_req) begin
                check("dmem_we", 32'(bus.dmem_we), 32'(m_we));
                check("dmem_addr", bus.dmem_addr, m_addr);
                if (m_we) check("dmem_wdata", bus.dmem_wdata, m_wdata);
            end
        end
    end

    function automatic int nbytes(input logic [2:0] sz);
        case (sz)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic bit m_is_fault(input bit wr, input bit rd, input logic [2:0] sz, input logic [31:0] a);
        int off;
        off = int'(a % 32'd4);
        if (wr && rd) return 1'b1;
        if (sz == 3'd3 || sz == 3'd6 || sz == 3'd7) return 1'b1;
        if (wr && (sz == 3'd4 || sz == 3'd5)) return 1'b1;
        if ((sz == 3'd1 || sz == 3'd5) && (off % 2) != 0) return 1'b1;
        if (sz == 3'd2 && off != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_strobe(input logic [2:0] sz, input logic [31:0] a);
        int v;
        v = ((1 << nbytes(sz)) - 1) << int'(a % 32'd4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_lanes(input logic [31:0] d, input logic [2:0] sz);
        if (nbytes(sz) == 1) return (d & 32'h0000_00FF) * 32'h0101_0101;
        if (nbytes(sz) == 2) return (d & 32'h0000_FFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [2:0] sz, input logic [31:0] a);
        logic [63:0] v;
        int          n;
        n = nbytes(sz);
        v = ({32'b0, rdata} >> (8 * int'(a % 32'd4))) & ((64'd1 << (8 * n)) - 64'd1);
        if (sz < 3'd4 && n < 4 && v[8*n-1]) v = v - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] rd, input logic [31:0] sel, input logic [31:0] pc,
                          input logic wr, input logic rdn, input logic [31:0] wd, input logic [2:0] sz);
        i_rd = rd; i_rd_sel = sel; i_pc = pc;
        wr_en = wr; rd_en = rdn; i_mem_wr_data = wd; rw_size = sz;
    endtask

    // ack_after: WAIT cycles without ack before the ack cycle (-1 = never). done_halt: halt cycles in DONE.
    task automatic run_op(input logic [31:0] rd, input logic [31:0] sel, input logic [31:0] pc,
                          input logic wr, input logic rdn, input logic [31:0] wd, input logic [2:0] sz,
                          input int ack_after, input logic [31:0] rdata, input int done_halt);
        bit mem, timed_out, finished;
        set_in(rd, sel, pc, wr, rdn, wd, sz);
        halt = 1'b0;
        mem = wr | rdn;
        m_stall = mem;
        step();
        m_fault = 1'b0;
        if (!mem) begin
            m_rd = rd; m_sel = sel; m_pc = pc; m_stall = 1'b0;
            return;
        end
        if (m_is_fault(wr, rdn, sz, rd)) begin
            m_rd = 0; m_sel = 0; m_pc = pc; m_fault = 1'b1;
            set_in(0, 0, 0, 0, 0, 0, 0);
            m_stall = 1'b0;
            return;
        end
        m_req = 1'b1; m_we = wr; m_addr = rd - (rd % 32'd4);
        m_wdata = m_lanes(wd, sz);
        m_wstrb = wr ? m_strobe(sz, rd) : 4'b0000;
        m_rd = 0; m_sel = 0; m_stall = 1'b1;
        timed_out = 1'b0;
        finished = 1'b0;
        for (int k = 0; k < 64 && !finished; k++) begin
            bus.dmem_ack   = (k == ack_after);
            bus.dmem_rdata = (k == ack_after) ? rdata : 32'h5A5A_5A5A;
            step();
            bus.dmem_ack = 1'b0;
            if (k == ack_after) begin
                m_req = 1'b0; m_wstrb = 4'b0000; m_stall = 1'b0; finished = 1'b1;
            end else if (k + 1 == TO) begin
                m_req = 1'b0; m_wstrb = 4'b0000; m_fault = 1'b1; m_stall = 1'b0;
                timed_out = 1'b1; finished = 1'b1;
            end
        end
        if (!finished) check("wait_bound", 32'(finished), 32'd1);
        // Upstream has advanced; a new store shows up and must be ignored while in DONE.
        set_in(32'h200, 32'd9, 32'h400, 1'b1, 1'b0, 32'hFFFF_FFFF, 3'd2);
        m_stall = 1'b0;
        for (int h = 0; h < done_halt; h++) begin
            halt = 1'b1;
            step();
            m_fault = 1'b0;
        end
        halt = 1'b0;
        step();
        m_fault = 1'b0;
        m_rd  = (timed_out || wr) ? 32'd0 : m_load(rdata, sz, rd);
        m_sel = (timed_out || wr) ? 32'd0 : sel;
        m_pc  = pc;
        set_in(0, 0, 0, 0, 0, 0, 0);
        m_stall = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; halt = 1'b0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        m_stall = 0; m_req = 0; m_we = 0; m_fault = 0;
        m_rd = 0; m_sel = 0; m_pc = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0;

        check("pin_sb_wdata", m_lanes(32'h0000_00AB, 3'd0), 32'hABAB_ABAB);
        check("pin_sb_wstrb", 32'(m_strobe(3'd0, 32'h103)), 32'h8);
        check("pin_sh_wstrb", 32'(m_strobe(3'd1, 32'h106)), 32'hC);
        check("pin_lh", m_load(32'h8001_0000, 3'd1, 32'h102), 32'hFFFF_8001);
        check("pin_lhu", m_load(32'h8001_0000, 3'd5, 32'h102), 32'h0000_8001);
        check("pin_lb", m_load(32'h1234_80FF, 3'd0, 32'h101), 32'hFFFF_FF80);
        check("pin_lw_misaligned", 32'(m_is_fault(1'b0, 1'b1, 3'd2, 32'h101)), 32'd1);

        step();
        chk_en = 1'b1;
        step();
        check("rst_addr", bus.dmem_addr, 32'h0);
        check("rst_wdata", bus.dmem_wdata, 32'h0);
        check("rst_we", 32'(bus.dmem_we), 32'h0);
        reset = 1'b0;

        run_op(32'h1234, 32'd5, 32'h10, 0, 0, 0, 3'd0, -1, 0, 0);
        check("alu_o_rd", o_rd, 32'h1234);
        check("alu_o_rd_sel", o_rd_sel, 32'd5);
        // SB, ack in the second WAIT cycle
        run_op(32'h103, 32'd6, 32'h14, 1, 0, 32'h0000_00AB, 3'd0, 1, 0, 0);
        run_op(32'h102, 32'd7, 32'h18, 0, 1, 0, 3'd1, 0, 32'h8001_0000, 0);
        check("lh_o_rd", o_rd, 32'hFFFF_8001);
        check("lh_o_rd_sel", o_rd_sel, 32'd7);
        run_op(32'h102, 32'd8, 32'h1C, 0, 1, 0, 3'd5, 0, 32'h8001_0000, 0);
        check("lhu_o_rd", o_rd, 32'h0000_8001);
        run_op(32'h101, 32'd10, 32'h20, 0, 1, 0, 3'd0, 2, 32'h1234_80FF, 0);
        run_op(32'h103, 32'd11, 32'h24, 0, 1, 0, 3'd4, 0, 32'hFE00_0000, 0);
        run_op(32'h104, 32'd12, 32'h28, 0, 1, 0, 3'd2, 1, 32'hDEAD_BEEF, 0);
        run_op(32'h106, 32'd13, 32'h2C, 1, 0, 32'h1234_ABCD, 3'd1, 0, 0, 0);
        run_op(32'h108, 32'd14, 32'h30, 1, 0, 32'hCAFE_F00D, 3'd2, 0, 0, 0);

        // Fault bubbles: misaligned W/H, illegal size codes, both enables, unsigned store
        run_op(32'h101, 32'd15, 32'h34, 0, 1, 0, 3'd2, 0, 0, 0);
        check("lw_mis_sel", o_rd_sel, 32'd0);
        run_op(32'h100, 32'd16, 32'h38, 0, 1, 0, 3'd3, 0, 0, 0);
        run_op(32'h100, 32'd17, 32'h3C, 1, 1, 0, 3'd2, 0, 0, 0);
        run_op(32'h103, 32'd18, 32'h40, 0, 1, 0, 3'd1, 0, 0, 0);
        run_op(32'h100, 32'd19, 32'h44, 1, 0, 0, 3'd4, 0, 0, 0);
        run_op(32'h100, 32'd20, 32'h48, 0, 1, 0, 3'd7, 0, 0, 0);

        // Timeout, then ack on the last allowed WAIT cycle
        run_op(32'h10C, 32'd21, 32'h4C, 0, 1, 0, 3'd2, -1, 0, 0);
        check("to_o_rd_sel", o_rd_sel, 32'd0);
        run_op(32'h10C, 32'd22, 32'h50, 0, 1, 0, 3'd2, TO - 1, 32'h0BAD_CAFE, 0);
        check("to_edge_o_rd", o_rd, 32'h0BAD_CAFE);

        // Halt held in DONE keeps outputs until released
        run_op(32'h110, 32'd23, 32'h54, 0, 1, 0, 3'd2, 0, 32'h7777_1111, 3);

        // Ack outside WAIT is ignored
        run_op(32'h55AA, 32'd24, 32'h58, 0, 0, 0, 3'd0, -1, 0, 0);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h1357_9BDF;
        run_op(32'h66BB, 32'd25, 32'h5C, 0, 0, 0, 3'd0, -1, 0, 0);
        bus.dmem_ack = 1'b0;

        // Halt in IDLE: bubble, no accept, PC holds
        set_in(32'h114, 32'd26, 32'h60, 0, 1, 0, 3'd2);
        halt = 1'b1;
        m_stall = 1'b0;
        step();
        m_rd = 0; m_sel = 0; m_fault = 0;
        halt = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        m_stall = 1'b0;

        // Reset while WAIT
        set_in(32'h120, 32'd4, 32'h64, 0, 1, 0, 3'd2);
        m_stall = 1'b1;
        step();
        m_req = 1; m_we = 0; m_addr = 32'h120; m_wstrb = 0; m_rd = 0; m_sel = 0; m_fault = 0;
        step();
        reset = 1'b1;
        step();
        m_req = 0; m_we = 0; m_wstrb = 0; m_fault = 0; m_rd = 0; m_sel = 0; m_pc = 0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        m_stall = 1'b0;
        check("rst_wait_addr", bus.dmem_addr, 32'h0);
        check("rst_wait_wdata", bus.dmem_wdata, 32'h0);
        reset = 1'b0;
        run_op(32'h4321, 32'd3, 32'h68, 0, 0, 0, 3'd0, -1, 0, 0);
        run_op(32'h104, 32'd2, 32'h6C, 0, 1, 0, 3'd2, 0, 32'h2468_ACE0, 0);
        step();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
